// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchroniser, debounce FSM, press/release/long
// event pulses, debounced level and a wrapping press counter.
module button_debounce #(
  parameter int STABLE_CYCLES = 270000,
  parameter int LONG_CYCLES   = 27000000,
  parameter int CNT_W         = 25,
  parameter int COUNT_W       = 16,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               btn_in,
  output logic               btn_level,
  output logic               press_pulse,
  output logic               release_pulse,
  output logic               long_pulse,
  output logic [COUNT_W-1:0] press_count
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  localparam logic             REL_LVL  = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] LONG_C   = CNT_W'(LONG_CYCLES);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   hold_q, hold_d, hold_inc;
  logic               s1_q, s2_q;
  logic               p;
  logic               level_q, level_d;
  logic               press_q, press_d;
  logic               rel_q, rel_d;
  logic               long_q, long_d;
  logic [COUNT_W-1:0] count_q, count_d;

  assign p        = (ACTIVE_LOW != 0) ? ~s2_q : s2_q;
  assign hold_inc = hold_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        hold_d = '0;
        if (p) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!p) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_C) begin
          state_d = HELD;
          press_d = 1'b1;
          count_d = count_q + 1'b1;
          hold_d  = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD, RELEASE_WAIT: begin
        // Saturating hold timer; the pulse fires only on the step into LONG_C.
        if (hold_q != LONG_C) begin
          hold_d = hold_inc;
          long_d = (hold_inc == LONG_C);
        end
        if (state_q == HELD) begin
          if (!p) begin
            state_d = RELEASE_WAIT;
            cnt_d   = CNT_W'(1);
          end else begin
            cnt_d = '0;
          end
        end else if (p) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_C) begin
          state_d = IDLE;
          rel_d   = 1'b1;
          cnt_d   = '0;
          hold_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        hold_d  = '0;
      end
    endcase
    level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      s1_q    <= REL_LVL;
      s2_q    <= REL_LVL;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      s1_q    <= btn_in;
      s2_q    <= s1_q;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      count_q <= count_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_pulse    = long_q;
  assign press_count   = count_q;

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: three instances (active-low, 2-bit counter,
// active-high on the inverted pin) checked against hand-computed event edges.
module tb_button_debounce;

  typedef struct {
    int kind;   // 0 press, 1 release, 2 long
    int cyc;
    int cnt;
  } ev_t;

  typedef struct {
    int   cyc;
    logic lvl;
    int   cnt;
  } lv_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b1;
  logic btn_n;
  int   cyc = 0;
  logic done = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_press = 0;

  ev_t exp_q [3][$];
  lv_t lvq   [3][$];

  logic        lvl_a, prs_a, rel_a, lng_a;
  logic        lvl_b, prs_b, rel_b, lng_b;
  logic        lvl_c, prs_c, rel_c, lng_c;
  logic [15:0] cnt_a, cnt_c;
  logic [1:0]  cnt_b;
  logic [2:0]  pl   [3];
  logic        lvl  [3];
  logic [15:0] cntv [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign btn_n = ~btn;

  button_debounce #(.STABLE_CYCLES(4), .LONG_CYCLES(20), .CNT_W(25), .COUNT_W(16), .ACTIVE_LOW(1)) dut_a (
    .sys_clk(clk), .sys_rst(rst), .btn_in(btn), .btn_level(lvl_a), .press_pulse(prs_a),
    .release_pulse(rel_a), .long_pulse(lng_a), .press_count(cnt_a));
  button_debounce #(.STABLE_CYCLES(4), .LONG_CYCLES(20), .CNT_W(25), .COUNT_W(2), .ACTIVE_LOW(1)) dut_b (
    .sys_clk(clk), .sys_rst(rst), .btn_in(btn), .btn_level(lvl_b), .press_pulse(prs_b),
    .release_pulse(rel_b), .long_pulse(lng_b), .press_count(cnt_b));
  button_debounce #(.STABLE_CYCLES(4), .LONG_CYCLES(20), .CNT_W(25), .COUNT_W(16), .ACTIVE_LOW(0)) dut_c (
    .sys_clk(clk), .sys_rst(rst), .btn_in(btn_n), .btn_level(lvl_c), .press_pulse(prs_c),
    .release_pulse(rel_c), .long_pulse(lng_c), .press_count(cnt_c));

  assign pl[0] = {lng_a, rel_a, prs_a};
  assign pl[1] = {lng_b, rel_b, prs_b};
  assign pl[2] = {lng_c, rel_c, prs_c};
  assign lvl[0] = lvl_a;
  assign lvl[1] = lvl_b;
  assign lvl[2] = lvl_c;
  assign cntv[0] = cnt_a;
  assign cntv[1] = {14'd0, cnt_b};
  assign cntv[2] = cnt_c;

  function automatic int cnt_for(input int i, input int n);
    return (i == 1) ? (n % 4) : n;
  endfunction

  task automatic push_ev(input int kind, input int c);
    for (int i = 0; i < 3; i++) exp_q[i].push_back('{kind: kind, cyc: c, cnt: cnt_for(i, n_press)});
  endtask

  task automatic check_at(input int c, input logic l, input int n);
    for (int i = 0; i < 3; i++) lvq[i].push_back('{cyc: c, lvl: l, cnt: cnt_for(i, n)});
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Value v is first sampled by posedge number e.
  task automatic drive_at(input int e, input logic v);
    wait_until(e - 1);
    btn = v;
  endtask

  // Monitor: pops expected events on every pulse and expected level/count at scheduled cycles.
  always @(negedge clk) begin
    ev_t ev;
    lv_t lv;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 3; k++) begin
        if (pl[i][k]) begin
          n_tests++;
          if (exp_q[i].size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse dut%0d kind=%0d at edge %0d cnt=%0d", i, k, cyc, cntv[i]);
          end else begin
            ev = exp_q[i].pop_front();
            if (ev.kind != k || ev.cyc != cyc || ev.cnt != int'(cntv[i])) begin
              n_fail++;
              $display("FAIL pulse dut%0d got kind=%0d edge=%0d cnt=%0d want kind=%0d edge=%0d cnt=%0d",
                       i, k, cyc, cntv[i], ev.kind, ev.cyc, ev.cnt);
            end
          end
        end
      end
      while (lvq[i].size() != 0 && lvq[i][0].cyc <= cyc) begin
        lv = lvq[i].pop_front();
        n_tests++;
        if (lv.cyc != cyc || lvl[i] !== lv.lvl || int'(cntv[i]) != lv.cnt) begin
          n_fail++;
          $display("FAIL level dut%0d edge=%0d got lvl=%b cnt=%0d want edge=%0d lvl=%b cnt=%0d",
                   i, cyc, lvl[i], cntv[i], lv.cyc, lv.lvl, lv.cnt);
        end
      end
    end
    if (done) begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (exp_q[i].size() != 0 || lvq[i].size() != 0) begin
          n_fail++;
          $display("FAIL leftover dut%0d got %0d events %0d checks pending want 0", i,
                   exp_q[i].size(), lvq[i].size());
        end
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  initial begin
    int e0, ea, ef, r0, b;
    wait_until(3);
    check_at(3, 1'b0, 0);
    rst = 1'b0;

    // Clean press then short release.
    e0 = 8;
    drive_at(e0, 1'b0);
    check_at(e0 + 5, 1'b0, 0);
    n_press = 1;
    push_ev(0, e0 + 6);
    check_at(e0 + 6, 1'b1, 1);
    r0 = e0 + 13;
    drive_at(r0, 1'b1);
    check_at(r0 + 5, 1'b1, 1);
    push_ev(1, r0 + 6);
    check_at(r0 + 6, 1'b0, 1);

    // Press bounce, long hold with a release bounce, clean release.
    ea = r0 + 12;
    drive_at(ea, 1'b0);
    drive_at(ea + 3, 1'b1);
    ef = ea + 5;
    drive_at(ef, 1'b0);
    check_at(ef + 5, 1'b0, 1);
    n_press = 2;
    push_ev(0, ef + 6);
    check_at(ef + 6, 1'b1, 2);
    push_ev(2, ef + 26);
    check_at(ef + 36, 1'b1, 2);
    drive_at(ef + 30, 1'b1);
    drive_at(ef + 32, 1'b0);
    r0 = ef + 40;
    drive_at(r0, 1'b1);
    push_ev(1, r0 + 6);
    check_at(r0 + 6, 1'b0, 2);

    // Reset while HELD with the button still down.
    e0 = r0 + 12;
    drive_at(e0, 1'b0);
    n_press = 3;
    push_ev(0, e0 + 6);
    check_at(e0 + 9, 1'b1, 3);
    check_at(e0 + 10, 1'b0, 0);
    wait_until(e0 + 9);
    rst = 1'b1;
    wait_until(e0 + 11);
    rst = 1'b0;
    n_press = 0;
    check_at(e0 + 17, 1'b0, 0);
    n_press = 1;
    push_ev(0, e0 + 18);
    check_at(e0 + 18, 1'b1, 1);
    drive_at(e0 + 25, 1'b1);
    push_ev(1, e0 + 31);

    // Reset, then five clean presses to wrap the 2-bit counter.
    wait_until(e0 + 35);
    rst = 1'b1;
    wait_until(e0 + 37);
    rst = 1'b0;
    n_press = 0;
    check_at(e0 + 38, 1'b0, 0);
    b = e0 + 40;
    for (int k = 0; k < 5; k++) begin
      drive_at(b, 1'b0);
      n_press++;
      push_ev(0, b + 6);
      drive_at(b + 10, 1'b1);
      push_ev(1, b + 16);
      b += 20;
    end
    check_at(b + 2, 1'b0, 5);
    wait_until(b + 6);
    done = 1'b1;
  end

endmodule
